// File: rtl/issue_queue_if.sv
// Rename-to-issue handshake bundle for issue_queue: enqueue port,
// result wakeup broadcast, flush, and the issue register port.
interface issue_queue_if #(
  parameter int DEPTH        = 16,
  parameter int MAX_OPERANDS = 3,
  parameter int PRN_BITS     = 6,
  parameter int INST_ID_BITS = 6,
  parameter int WAKE_PORTS   = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                                   in_valid;
  logic                                   in_ready;
  logic [INST_ID_BITS-1:0]                in_inst_id;
  logic [31:0]                            in_raw_instr;
  logic [63:0]                            in_pc;
  logic [MAX_OPERANDS-1:0]                in_src_valid;
  logic [MAX_OPERANDS-1:0]                in_src_ready;
  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  in_src_prn;
  logic [MAX_OPERANDS-1:0]                in_dst_valid;
  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  in_dst_prn;

  logic [WAKE_PORTS-1:0]                  wake_valid;
  logic [WAKE_PORTS-1:0][PRN_BITS-1:0]    wake_prn;
  logic                                   flush;

  logic                                   issue_valid;
  logic                                   issue_ready;
  logic [INST_ID_BITS-1:0]                issue_inst_id;
  logic [31:0]                            issue_raw_instr;
  logic [63:0]                            issue_pc;
  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  issue_src_prn;
  logic [MAX_OPERANDS-1:0]                issue_dst_valid;
  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  issue_dst_prn;
  logic [CW-1:0]                          count;

  modport master (
    output in_valid, in_inst_id, in_raw_instr, in_pc,
    output in_src_valid, in_src_ready, in_src_prn,
    output in_dst_valid, in_dst_prn,
    output wake_valid, wake_prn, flush, issue_ready,
    input  in_ready, issue_valid, issue_inst_id,
    input  issue_raw_instr, issue_pc, issue_src_prn,
    input  issue_dst_valid, issue_dst_prn, count
  );

  modport slave (
    input  in_valid, in_inst_id, in_raw_instr, in_pc,
    input  in_src_valid, in_src_ready, in_src_prn,
    input  in_dst_valid, in_dst_prn,
    input  wake_valid, wake_prn, flush, issue_ready,
    output in_ready, issue_valid, issue_inst_id,
    output issue_raw_instr, issue_pc, issue_src_prn,
    output issue_dst_valid, issue_dst_prn, count
  );
endinterface

// File: rtl/issue_queue.sv
// Out-of-order issue queue: wakeup on result broadcast, oldest-ready
// select through an age matrix, single registered issue slot.
module issue_queue #(
  parameter int DEPTH        = 16,
  parameter int MAX_OPERANDS = 3,
  parameter int PRN_BITS     = 6,
  parameter int INST_ID_BITS = 6,
  parameter int WAKE_PORTS   = 4
) (
  input logic         clk,
  input logic         rst,
  issue_queue_if.slave bus
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  typedef logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] prn_vec_t;
  typedef logic [MAX_OPERANDS-1:0]               op_vec_t;

  logic [DEPTH-1:0]        valid;
  logic [DEPTH-1:0]        older [DEPTH];
  logic [INST_ID_BITS-1:0] ent_id [DEPTH];
  logic [31:0]             ent_raw [DEPTH];
  logic [63:0]             ent_pc [DEPTH];
  op_vec_t                 ent_sv [DEPTH];
  op_vec_t                 ent_sr [DEPTH];
  op_vec_t                 ent_dv [DEPTH];
  prn_vec_t                ent_sp [DEPTH];
  prn_vec_t                ent_dp [DEPTH];

  logic [CW-1:0]           count_q;
  logic                    iss_valid;
  logic [INST_ID_BITS-1:0] iss_id;
  logic [31:0]             iss_raw;
  logic [63:0]             iss_pc;
  prn_vec_t                iss_sp;
  op_vec_t                 iss_dv;
  prn_vec_t                iss_dp;

  logic [DEPTH-1:0]        elig;
  logic [DEPTH-1:0]        blocked;
  logic [DEPTH-1:0]        sel;
  logic [IW-1:0]           sel_idx;
  logic [IW-1:0]           free_idx;
  op_vec_t                 enq_sr;
  logic                    enq;
  logic                    load;
  logic                    do_issue;

  function automatic logic woke(
    input logic [PRN_BITS-1:0]                 p,
    input logic [WAKE_PORTS-1:0]               wv,
    input logic [WAKE_PORTS-1:0][PRN_BITS-1:0] wp
  );
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < WAKE_PORTS; k++)
      hit = hit | (wv[k] & (wp[k] == p));
    return hit;
  endfunction

  always_comb begin
    for (int i = 0; i < DEPTH; i++)
      elig[i] = valid[i] & (&(~ent_sv[i] | ent_sr[i]));
  end

  // An eligible entry is picked only if no older entry is eligible.
  always_comb begin
    blocked = '0;
    sel_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++)
        blocked[i] = blocked[i] | (elig[j] & older[j][i]);
    end
    sel = elig & ~blocked;
    for (int i = 0; i < DEPTH; i++)
      if (sel[i]) sel_idx = IW'(i);
  end

  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (!valid[i]) free_idx = IW'(i);
  end

  always_comb begin
    for (int s = 0; s < MAX_OPERANDS; s++)
      enq_sr[s] = bus.in_src_ready[s]
                | woke(bus.in_src_prn[s], bus.wake_valid, bus.wake_prn);
  end

  assign bus.in_ready = (count_q < CW'(DEPTH)) && !bus.flush;
  assign enq          = bus.in_valid && bus.in_ready;
  assign load         = !iss_valid || bus.issue_ready;
  assign do_issue     = load && (|elig);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
      for (int i = 0; i < DEPTH; i++)
        older[i] <= '0;
    end else if (bus.flush) begin
      valid <= '0;
    end else begin
      if (do_issue)
        valid[sel_idx] <= 1'b0;
      if (enq) begin
        valid[free_idx] <= 1'b1;
        older[free_idx] <= '0;
        for (int j = 0; j < DEPTH; j++)
          older[j][free_idx] <= valid[j];
      end
    end
  end

  // Payload needs no reset: it is only observed through a valid entry.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++)
      for (int s = 0; s < MAX_OPERANDS; s++)
        if (woke(ent_sp[i][s], bus.wake_valid, bus.wake_prn))
          ent_sr[i][s] <= 1'b1;
    if (enq) begin
      ent_id[free_idx]  <= bus.in_inst_id;
      ent_raw[free_idx] <= bus.in_raw_instr;
      ent_pc[free_idx]  <= bus.in_pc;
      ent_sv[free_idx]  <= bus.in_src_valid;
      ent_sr[free_idx]  <= enq_sr;
      ent_sp[free_idx]  <= bus.in_src_prn;
      ent_dv[free_idx]  <= bus.in_dst_valid;
      ent_dp[free_idx]  <= bus.in_dst_prn;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iss_valid <= 1'b0;
      iss_id    <= '0;
      iss_raw   <= '0;
      iss_pc    <= '0;
      iss_sp    <= '0;
      iss_dv    <= '0;
      iss_dp    <= '0;
    end else if (bus.flush) begin
      iss_valid <= 1'b0;
    end else if (load) begin
      iss_valid <= |elig;
      if (|elig) begin
        iss_id  <= ent_id[sel_idx];
        iss_raw <= ent_raw[sel_idx];
        iss_pc  <= ent_pc[sel_idx];
        iss_sp  <= ent_sp[sel_idx];
        iss_dv  <= ent_dv[sel_idx];
        iss_dp  <= ent_dp[sel_idx];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count_q <= '0;
    else if (bus.flush)
      count_q <= '0;
    else
      count_q <= count_q + CW'(enq) - CW'(do_issue);
  end

  assign bus.issue_valid     = iss_valid;
  assign bus.issue_inst_id   = iss_id;
  assign bus.issue_raw_instr = iss_raw;
  assign bus.issue_pc        = iss_pc;
  assign bus.issue_src_prn   = iss_sp;
  assign bus.issue_dst_valid = iss_dv;
  assign bus.issue_dst_prn   = iss_dp;
  assign bus.count           = count_q;
endmodule

// File: tb/tb_issue_queue.sv
// Bench for issue_queue: age-ordered list model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_issue_queue;
  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  issue_queue_if #(.DEPTH(16)) bus ();

  issue_queue #(
    .DEPTH(16), .MAX_OPERANDS(3), .PRN_BITS(6),
    .INST_ID_BITS(6), .WAKE_PORTS(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]       id;
    logic [31:0]      raw;
    logic [63:0]      pc;
    logic [2:0]       sv;
    logic [2:0]       sr;
    logic [2:0][5:0]  sp;
    logic [2:0]       dv;
    logic [2:0][5:0]  dp;
  } ent_t;

  ent_t mq[$];
  ent_t miss;
  bit   miss_v;
  ent_t me;
  int   mk;
  int   mn;

  function automatic bit hit(input logic [5:0] p);
    bit h;
    h = 1'b0;
    for (int k = 0; k < 4; k++)
      if (bus.wake_valid[k] && bus.wake_prn[k] == p) h = 1'b1;
    return h;
  endfunction

  function automatic bit rdy(input ent_t e);
    return ((~e.sv | e.sr) == 3'b111);
  endfunction

  // Model: list ordered oldest first; one issue slot.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      miss_v = 1'b0;
    end else if (bus.flush) begin
      mq.delete();
      miss_v = 1'b0;
    end else begin
      mn = mq.size();
      mk = -1;
      for (int i = 0; i < mn; i++)
        if (mk < 0 && rdy(mq[i])) mk = i;
      if (!miss_v || bus.issue_ready) begin
        if (mk >= 0) begin
          miss   = mq[mk];
          miss_v = 1'b1;
          mq.delete(mk);
        end else begin
          miss_v = 1'b0;
        end
      end
      for (int i = 0; i < mq.size(); i++) begin
        me = mq[i];
        for (int s = 0; s < 3; s++)
          if (hit(me.sp[s])) me.sr[s] = 1'b1;
        mq[i] = me;
      end
      if (bus.in_valid && mn < 16) begin
        me.id  = bus.in_inst_id;
        me.raw = bus.in_raw_instr;
        me.pc  = bus.in_pc;
        me.sv  = bus.in_src_valid;
        me.sp  = bus.in_src_prn;
        me.dv  = bus.in_dst_valid;
        me.dp  = bus.in_dst_prn;
        for (int s = 0; s < 3; s++)
          me.sr[s] = bus.in_src_ready[s] | hit(me.sp[s]);
        mq.push_back(me);
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
               $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("count", 64'(bus.count), 64'(mq.size()));
      chk("in_ready", 64'(bus.in_ready),
          64'(mq.size() < 16 && !bus.flush));
      chk("issue_valid", 64'(bus.issue_valid), 64'(miss_v));
      if (miss_v) begin
        chk("issue_inst_id", 64'(bus.issue_inst_id), 64'(miss.id));
        chk("issue_raw", 64'(bus.issue_raw_instr), 64'(miss.raw));
        chk("issue_pc", bus.issue_pc, miss.pc);
        chk("issue_src_prn", 64'(bus.issue_src_prn), 64'(miss.sp));
        chk("issue_dst_valid", 64'(bus.issue_dst_valid), 64'(miss.dv));
        chk("issue_dst_prn", 64'(bus.issue_dst_prn), 64'(miss.dp));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid   = 1'b0;
    bus.wake_valid = '0;
    bus.flush      = 1'b0;
  endtask

  task automatic enq(input int id, input logic [2:0] sv,
                     input logic [2:0] sr, input logic [5:0] p0,
                     input logic [5:0] p1, input logic [5:0] p2);
    bus.in_valid     = 1'b1;
    bus.in_inst_id   = 6'(id);
    bus.in_raw_instr = 32'hA000_0000 | 32'(id);
    bus.in_pc        = 64'h8000_0000 + 64'(id * 4);
    bus.in_src_valid = sv;
    bus.in_src_ready = sr;
    bus.in_src_prn   = {p2, p1, p0};
    bus.in_dst_valid = 3'b001;
    bus.in_dst_prn   = {6'd0, 6'd0, 6'(id + 32)};
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    idle();
    bus.issue_ready  = 1'b1;
    bus.in_inst_id   = '0;
    bus.in_raw_instr = '0;
    bus.in_pc        = '0;
    bus.in_src_valid = '0;
    bus.in_src_ready = '0;
    bus.in_src_prn   = '0;
    bus.in_dst_valid = '0;
    bus.in_dst_prn   = '0;
    bus.wake_prn     = '0;
    tick();
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_issue_valid", 64'(bus.issue_valid), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_payload", bus.issue_pc, 64'd0);
    rst = 1'b0;
    tick();

    // Ready instruction issues one edge after enqueue.
    enq(5, 3'b111, 3'b111, 6'd1, 6'd2, 6'd3);
    tick();
    idle();
    chk("t39_count_enq", 64'(bus.count), 64'd1);
    chk("t39_no_issue_yet", 64'(bus.issue_valid), 64'd0);
    tick();
    chk("t39_issue_valid", 64'(bus.issue_valid), 64'd1);
    chk("t39_issue_id", 64'(bus.issue_inst_id), 64'd5);
    chk("t39_count", 64'(bus.count), 64'd0);
    tick();
    chk("t39_drain", 64'(bus.issue_valid), 64'd0);

    // Younger ready instruction passes older blocked one.
    enq(1, 3'b001, 3'b000, 6'd12, 6'd0, 6'd0);
    tick();
    enq(2, 3'b001, 3'b001, 6'd13, 6'd0, 6'd0);
    tick();
    idle();
    tick();
    chk("t40_first_id", 64'(bus.issue_inst_id), 64'd2);
    bus.wake_valid = 4'b0001;
    bus.wake_prn   = {6'd0, 6'd0, 6'd0, 6'd12};
    tick();
    idle();
    chk("t40_wake_edge_valid", 64'(bus.issue_valid), 64'd0);
    tick();
    chk("t40_second_valid", 64'(bus.issue_valid), 64'd1);
    chk("t40_second_id", 64'(bus.issue_inst_id), 64'd1);
    tick();

    // Fill, drop overflow, then wake all and issue in age order.
    for (int i = 0; i < 16; i++) begin
      enq(16 + i, 3'b001, 3'b000, 6'(40 + i), 6'd0, 6'd0);
      tick();
    end
    chk("t41_full_count", 64'(bus.count), 64'd16);
    chk("t41_full_ready", 64'(bus.in_ready), 64'd0);
    enq(60, 3'b001, 3'b000, 6'd56, 6'd0, 6'd0);
    tick();
    chk("t41_drop_count", 64'(bus.count), 64'd16);
    idle();
    for (int k = 0; k < 18; k++) begin
      if (k < 4) begin
        bus.wake_valid = 4'b1111;
        bus.wake_prn   = {6'(43 + 4 * k), 6'(42 + 4 * k),
                          6'(41 + 4 * k), 6'(40 + 4 * k)};
      end else begin
        bus.wake_valid = '0;
      end
      tick();
      if (k >= 1 && k <= 16)
        chk("t41_order", 64'(bus.issue_inst_id), 64'(16 + k - 1));
    end
    chk("t41_done_valid", 64'(bus.issue_valid), 64'd0);
    chk("t41_done_count", 64'(bus.count), 64'd0);

    // Wake bypass on the enqueue cycle.
    enq(9, 3'b001, 3'b000, 6'd7, 6'd0, 6'd0);
    bus.wake_valid = 4'b0010;
    bus.wake_prn   = {6'd0, 6'd0, 6'd7, 6'd0};
    tick();
    idle();
    tick();
    chk("t42_valid", 64'(bus.issue_valid), 64'd1);
    chk("t42_id", 64'(bus.issue_inst_id), 64'd9);
    tick();

    // Back-pressure holds the issue register.
    bus.issue_ready = 1'b0;
    enq(10, 3'b011, 3'b011, 6'd4, 6'd5, 6'd0);
    tick();
    enq(11, 3'b000, 3'b000, 6'd0, 6'd0, 6'd0);
    tick();
    idle();
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t43_hold_id", 64'(bus.issue_inst_id), 64'd10);
      chk("t43_hold_pc", bus.issue_pc, 64'h8000_0028);
      chk("t43_hold_count", 64'(bus.count), 64'd1);
    end
    bus.issue_ready = 1'b1;
    tick();
    chk("t43_next_id", 64'(bus.issue_inst_id), 64'd11);
    chk("t43_next_count", 64'(bus.count), 64'd0);
    tick();

    // Flush beats enqueue and wakeup.
    bus.issue_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      enq(20 + i, 3'b001, 3'b001, 6'd1, 6'd0, 6'd0);
      tick();
    end
    chk("t44_pre_count", 64'(bus.count), 64'd5);
    chk("t44_pre_id", 64'(bus.issue_inst_id), 64'd20);
    enq(30, 3'b000, 3'b000, 6'd0, 6'd0, 6'd0);
    bus.flush      = 1'b1;
    bus.wake_valid = 4'b0001;
    tick();
    chk("t44_count", 64'(bus.count), 64'd0);
    chk("t44_valid", 64'(bus.issue_valid), 64'd0);
    idle();
    bus.issue_ready = 1'b1;
    tick();
    chk("t44_after", 64'(bus.count), 64'd0);

    // Asynchronous reset mid-operation.
    enq(41, 3'b001, 3'b000, 6'd60, 6'd0, 6'd0);
    tick();
    enq(42, 3'b001, 3'b000, 6'd61, 6'd0, 6'd0);
    tick();
    idle();
    rst = 1'b1;
    #1;
    chk("t38_async_count", 64'(bus.count), 64'd0);
    chk("t38_async_ready", 64'(bus.in_ready), 64'd1);
    tick();
    rst = 1'b0;
    enq(43, 3'b111, 3'b111, 6'd1, 6'd2, 6'd3);
    tick();
    idle();
    chk("t38_first_count", 64'(bus.count), 64'd1);
    tick();
    chk("t38_first_id", 64'(bus.issue_inst_id), 64'd43);
    chk("t38_first_count0", 64'(bus.count), 64'd0);
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/issue_queue.md
ISSUE_QUEUE -- requirements
Module: issue_queue

Interface
REQ-001 Parameter DEPTH, default 16, number of queue entries (power of two, 2..64).
REQ-002 Parameter MAX_OPERANDS, default 3, source/destination operand slots per instruction.
REQ-003 Parameter PRN_BITS, default 6, physical register number width.
REQ-004 Parameter INST_ID_BITS, default 6, ROB instruction id width.
REQ-005 Parameter WAKE_PORTS, default 4, number of result-broadcast ports from functional units.
REQ-006 clk  in  1  sole clock; all state on rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 in_valid  in  1  renamer presents an instruction.
REQ-009 in_ready  out  1  queue accepts this cycle.
REQ-010 in_inst_id  in  INST_ID_BITS  ROB id.
REQ-011 in_raw_instr  in  32  instruction word.
REQ-012 in_pc  in  64  instruction PC.
REQ-013 in_src_valid/in_src_ready  in  1 x MAX_OPERANDS  operand used / already ready.
REQ-014 in_src_prn  in  PRN_BITS x MAX_OPERANDS  source PRNs.
REQ-015 in_dst_valid  in  1 x MAX_OPERANDS; in_dst_prn  in  PRN_BITS x MAX_OPERANDS  destinations.
REQ-016 wake_valid  in  1 x WAKE_PORTS; wake_prn  in  PRN_BITS x WAKE_PORTS  PRNs becoming ready.
REQ-017 flush  in  1  discard all queued and pending-issue instructions.
REQ-018 issue_valid  out  1  issue register holds an instruction.
REQ-019 issue_ready  in  1  functional unit consumes the issue register.
REQ-020 issue_inst_id, issue_raw_instr, issue_pc, issue_src_prn, issue_dst_valid, issue_dst_prn  out  widths as inputs  issued payload.
REQ-021 count  out  $clog2(DEPTH)+1  occupied entries (excluding issue register).

Function
REQ-022 Entry state: valid, payload, per-operand src_valid/src_ready, plus DEPTH x DEPTH age matrix (older-than bits).
REQ-023 in_ready SHALL be 1 iff count < DEPTH and flush = 0 (full -> 0, even if an entry frees this cycle).
REQ-024 Enqueue when in_valid && in_ready: lowest-index free entry written; marked younger than every valid entry.
REQ-025 Operand ready = !src_valid || src_ready; unused operands never block.
REQ-026 Wakeup: any wake_valid[k] with wake_prn[k] equal to a valid entry's src PRN sets that src_ready at the edge.
REQ-027 Wakeup bypass: a wake matching an enqueuing instruction's src PRN SHALL store src_ready = 1.
REQ-028 Eligible = valid entry with all operands ready (using pre-edge ready bits only).
REQ-029 Select: oldest eligible entry per age matrix; unique result.
REQ-030 Issue register loads selected entry when !issue_valid || issue_ready; selected entry freed same edge.
REQ-031 issue_valid and payload SHALL hold stable while issue_valid && !issue_ready.
REQ-032 Latency: instruction enqueued fully ready at edge N -> issue_valid at edge N+1 earliest; wake at edge N -> issue at N+1 earliest.
REQ-033 Simultaneous enqueue and select: both occur; count = count + 1 - 1.
REQ-034 If nothing eligible and issue_ready consumed, issue_valid SHALL clear next edge.
REQ-035 flush (synchronous, highest priority): all entries invalid, issue_valid = 0, count = 0 next edge; enqueue/wakeup that cycle ignored.
REQ-036 count SHALL never exceed DEPTH nor underflow.

Reset
REQ-037 On rst assertion, immediately: all entries invalid, age matrix zero, issue_valid = 0, count = 0, in_ready = 1 (when flush = 0); payload outputs 0.
REQ-038 Reset mid-operation discards all in-flight instructions; first enqueue after deassertion behaves as into empty queue.

Verification
REQ-039 Enqueue id 5 all srcs ready, issue_ready=1 -> issue_valid next edge, issue_inst_id=5, count back to 0.
REQ-040 Enqueue id 1 (src PRN 12 not ready) then id 2 (ready) -> id 2 issues first; wake PRN 12 -> id 1 issues one edge later.
REQ-041 Fill 16 entries none ready -> in_ready=0, count=16; extra in_valid dropped; wake all -> issue in enqueue order.
REQ-042 Enqueue src PRN 7 while wake_prn=7 same cycle -> instruction issues next edge without further wake.
REQ-043 Hold issue_ready=0 for 3 cycles with eligible entries -> payload stable, count unchanged.
REQ-044 Flush with 5 queued and issue_valid=1 (also in_valid=1) -> next edge count=0, issue_valid=0, nothing enqueued.
